// File: rtl/uart_pkg.sv
// Shared UART-side constants and types, used by the receive buffer and the block serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

   localparam int BYTE_W      = 8;
   localparam int BLOCK_BYTES = 16;

   // Serializer control states: waiting for a block, or streaming its bytes out.
   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

endpackage

// File: rtl/block_serializer.sv
// Block to byte-stream serializer: one NBYTES block in, NBYTES bytes out MSB-first. Optional byte_last via SERIALIZER_LAST_EN.
// Latency: byte 0 valid one cycle after block accept; one byte per cycle while byte_ready is high; NBYTES+1 cycle block period.
// Backpressure: byte_ready low stalls with byte_out/byte_valid held; block_ready only in IDLE, block_valid ignored while sending.
module block_serializer
   import uart_pkg::*;
#(
   parameter  int NBYTES = BLOCK_BYTES,
   localparam int CNT_W  = $clog2(NBYTES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [BYTE_W*NBYTES-1:0] block_in,
   input  logic                     block_valid,
   output logic                     block_ready,
   output logic [BYTE_W-1:0]        byte_out,
   output logic                     byte_valid,
   input  logic                     byte_ready,
   output logic                     busy
`ifdef SERIALIZER_LAST_EN
   ,
   output logic                     byte_last
`endif
);

   localparam int BLK_W = BYTE_W * NBYTES;

   ser_state_t        state_q;
   ser_state_t        state_d;
   logic [BLK_W-1:0]  shreg_q;
   logic [CNT_W-1:0]  idx_q;
   logic              load;
   logic              shift;
   logic              last_idx;

   // The byte on the wire is always the top of the shift register, so it is stable during a stall.
   assign byte_out = shreg_q[BLK_W-1 -: BYTE_W];
   assign last_idx = (idx_q == CNT_W'(NBYTES - 1));

`ifdef SERIALIZER_LAST_EN
   assign byte_last = byte_valid && last_idx;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SER_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus handshake outputs; the outputs depend on state_q only, never on the input strobes.
   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      shift       = 1'b0;
      block_ready = 1'b0;
      byte_valid  = 1'b0;
      busy        = 1'b0;
      case (state_q)
         SER_IDLE: begin
            block_ready = 1'b1;
            if (block_valid) begin
               load    = 1'b1;
               state_d = SER_SEND;
            end
         end
         SER_SEND: begin
            byte_valid = 1'b1;
            busy       = 1'b1;
            if (byte_ready) begin
               shift = 1'b1;
               if (last_idx) begin
                  state_d = SER_IDLE;
               end
            end
         end
         default: begin
            state_d = SER_IDLE;
         end
      endcase
   end

   // Shift register and byte index; the index stops at NBYTES-1 and is cleared by the next load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_q <= '0;
         idx_q   <= '0;
      end else if (load) begin
         shreg_q <= block_in;
         idx_q   <= '0;
      end else if (shift) begin
         shreg_q <= {shreg_q[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
         if (!last_idx) begin
            idx_q <= idx_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench for block_serializer: queue-based byte-stream model plus directed literal checks.
// Latency: n/a.
// Backpressure: byte_ready driven high, random, and held low on the last byte.
module tb_block_serializer;

   logic         clk;
   logic         rst;
   logic [127:0] block_in;
   logic         block_valid;
   logic         block_ready;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic         byte_ready;
   logic         busy;
`ifdef SERIALIZER_LAST_EN
   logic         byte_last;
`endif

   int ntests = 0;
   int nfail  = 0;
   bit rnd    = 0;

   // Expected byte stream still owed by the DUT, oldest first.
   logic [7:0] q[$];

   block_serializer dut (
      .clk         (clk),
      .rst         (rst),
      .block_in    (block_in),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .busy        (busy)
`ifdef SERIALIZER_LAST_EN
      ,
      .byte_last   (byte_last)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a busy serializer owes exactly the queued bytes; an idle one owes nothing and accepts.
   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
         check("rst_byte_valid", byte_valid, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_byte_out", byte_out, 8'h00);
`ifdef SERIALIZER_LAST_EN
         check("rst_byte_last", byte_last, 1'b0);
`endif
      end else begin
         check("block_ready", block_ready, q.size() == 0);
         check("byte_valid", byte_valid, q.size() != 0);
         check("busy", busy, q.size() != 0);
`ifdef SERIALIZER_LAST_EN
         check("byte_last", byte_last, q.size() == 1);
`endif
         if (q.size() != 0) begin
            check("byte_out", byte_out, q[0]);
            if (byte_ready) void'(q.pop_front());
         end else if (block_valid) begin
            for (int k = 0; k < 16; k++) q.push_back(block_in[8*(16-k)-1 -: 8]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rnd) byte_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic load(input logic [127:0] b);
      for (int i = 0; i < 50 && !block_ready; i++) cyc();
      check("load_ready", block_ready, 1'b1);
      block_in    = b;
      block_valid = 1'b1;
      cyc();
      block_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 400; i++) begin
         if (q.size() == 0 && block_ready) begin
            done = 1;
            break;
         end
         cyc();
      end
      check("drain_timeout", done, 1'b1);
   endtask

   initial begin
      logic [127:0] blk_a;
      logic [127:0] blk_b;
      logic [7:0]   e;
      blk_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      blk_b = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;

      rst         = 1'b0;
      block_in    = '0;
      block_valid = 1'b0;
      byte_ready  = 1'b0;
      repeat (3) cyc();
      rst = 1'b1;
      @(negedge clk);
      check("init_block_ready", block_ready, 1'b1);
      check("init_byte_valid", byte_valid, 1'b0);
      check("init_busy", busy, 1'b0);
      check("init_byte_out", byte_out, 8'h00);
      cyc();

      // Known block at full rate: 00,11,...,FF in consecutive cycles, ready again on cycle 17.
      byte_ready = 1'b1;
      load(blk_a);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         e = 8'(k * 17);
         check("lit_valid", byte_valid, 1'b1);
         check("lit_byte", byte_out, e);
      end
      @(negedge clk);
      check("lit_ready17", block_ready, 1'b1);
      check("lit_idle17", byte_valid, 1'b0);
      cyc();

      // Same block with random backpressure.
      rnd = 1;
      load(blk_a);
      wait_idle();
      rnd = 0;

      // A second block offered mid-transfer must be ignored.
      byte_ready = 1'b1;
      load(blk_a);
      repeat (4) cyc();
      block_in    = blk_b;
      block_valid = 1'b1;
      repeat (2) cyc();
      block_valid = 1'b0;
      wait_idle();

      // Reset after byte 5 has been taken, then a fresh block starts at its byte 0.
      load(blk_b);
      repeat (6) cyc();
      rst = 1'b0;
      #1;
      check("mid_rst_valid", byte_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_byte", byte_out, 8'h00);
      check("mid_rst_ready", block_ready, 1'b1);
      cyc();
      rst = 1'b1;
      cyc();
      load(blk_a);
      @(negedge clk);
      check("post_rst_byte0", byte_out, 8'h00);
      cyc();
      wait_idle();

      // Stall on the final byte.
      load(blk_a);
      for (int i = 0; i < 40 && q.size() != 1; i++) cyc();
      byte_ready = 1'b0;
      repeat (3) cyc();
      check("stall_last_byte", byte_out, 8'hFF);
`ifdef SERIALIZER_LAST_EN
      check("stall_last_flag", byte_last, 1'b1);
`endif
      byte_ready = 1'b1;
      wait_idle();

      // Random blocks, random backpressure, random gaps.
      rnd = 1;
      for (int n = 0; n < 8; n++) begin
         load({$urandom, $urandom, $urandom, $urandom});
         wait_idle();
         repeat ($urandom_range(0, 3)) cyc();
      end
      rnd = 0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
